// File: rtl/fir_pkg.sv
// Shared widths and arithmetic helpers for the FIR feed-forward section.
package fir_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_COEF_W    = 16;
    localparam int DEF_TAPS      = 3;
    localparam int DEF_OUT_SHIFT = 0;
    localparam int SAT_W         = 128;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-half-up shift then clamp to a signed width-bit range; returns {sat_flag, value}.
    function automatic logic [SAT_W:0] sat_round(input logic signed [SAT_W-1:0] acc,
                                                 input int shift,
                                                 input int width);
        logic signed [SAT_W-1:0] one_v;
        logic signed [SAT_W-1:0] r_v;
        logic signed [SAT_W-1:0] lim_v;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic [SAT_W:0]          res_v;
        one_v = {{(SAT_W-1){1'b0}}, 1'b1};
        if (shift > 0) begin
            r_v = (acc + (one_v <<< (shift - 1))) >>> shift;
        end else begin
            r_v = acc;
        end
        lim_v = one_v <<< (width - 1);
        max_v = lim_v - one_v;
        min_v = -lim_v;
        if (r_v > max_v) begin
            res_v = {1'b1, max_v};
        end else if (r_v < min_v) begin
            res_v = {1'b1, min_v};
        end else begin
            res_v = {1'b0, r_v};
        end
        return res_v;
    endfunction

endpackage

// File: rtl/fir_tap_mult.sv
// One registered full-width signed multiply for a single FIR tap.
module fir_tap_mult
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          x_i,
    input  logic [COEF_W-1:0]          h_i,
    output logic [DATA_W+COEF_W-1:0]   p_o
);

    localparam int P_W = DATA_W + COEF_W;

    logic [P_W-1:0] x_ext_s;
    logic [P_W-1:0] h_ext_s;
    logic [P_W-1:0] p_d;
    logic [P_W-1:0] p_q;

    // Both operands are sign-extended to the product width so the multiply is exact.
    always_comb begin
        x_ext_s = {{COEF_W{x_i[DATA_W-1]}}, x_i};
        h_ext_s = {{DATA_W{h_i[COEF_W-1]}}, h_i};
        p_d     = P_W'($signed(x_ext_s) * $signed(h_ext_s));
    end

    // Product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= {P_W{1'b0}};
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/fir_feedforward_param.sv
// Pipelined feed-forward FIR section: accept/shift, per-tap multiply, sum, round+saturate.
module fir_feedforward_param
    import fir_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int TAPS      = DEF_TAPS,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          coef_we,
    input  logic [clog2_min1(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]             coef_wdata,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_sat
);

    localparam int P_W = DATA_W + COEF_W;

    logic [DATA_W-1:0] x_q [TAPS];
    logic [DATA_W-1:0] x_d [TAPS];
    logic [COEF_W-1:0] h_q [TAPS];
    logic [COEF_W-1:0] h_d [TAPS];
    logic [P_W-1:0]    p_s [TAPS];
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [SAT_W-1:0]  acc_ext_s;
    logic              v0_q, v0_d;
    logic              v1_q, v1_d;
    logic              v2_q, v2_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        fir_tap_mult #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W)
        ) u_mult (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (x_q[k]),
            .h_i   (h_q[k]),
            .p_o   (p_s[k])
        );
    end

    // Next-state for delay line, coefficients, adder tree, valids and output stage.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            if (coef_we && (int'(coef_addr) == k)) begin
                h_d[k] = coef_wdata;
            end else begin
                h_d[k] = h_q[k];
            end
        end

        // Flush beats a coincident sample: the line is zeroed and the sample dropped.
        if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                x_d[k] = {DATA_W{1'b0}};
            end
        end else if (in_valid) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end else begin
            x_d = x_q;
        end

        acc_d = {ACC_W{1'b0}};
        for (int k = 0; k < TAPS; k++) begin
            acc_d = acc_d + {{(ACC_W-P_W){p_s[k][P_W-1]}}, p_s[k]};
        end

        v0_d        = in_valid && !flush;
        v1_d        = v0_q && !flush;
        v2_d        = v1_q && !flush;
        out_valid_d = v2_q && !flush;

        acc_ext_s = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        if (v2_q && !flush) begin
            out_data_d = DATA_W'(sat_round(acc_ext_s, OUT_SHIFT, DATA_W));
            out_sat_d  = 1'(sat_round(acc_ext_s, OUT_SHIFT, DATA_W) >> SAT_W);
        end else begin
            out_data_d = out_data_q;
            out_sat_d  = out_sat_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= {DATA_W{1'b0}};
                h_q[k] <= {COEF_W{1'b0}};
            end
            acc_q       <= {ACC_W{1'b0}};
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_sat_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            h_q         <= h_d;
            acc_q       <= acc_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_feedforward_param.sv
// Bench: two FIR instances (32-bit/no shift, 16-bit/shift 2) checked against a sample-history model.
module tb_fir_feedforward_param;

    logic clk_s   = 1'b0;
    logic rst_n_s = 1'b1;
    always #5 clk_s = ~clk_s;

    logic        flush_s      [2];
    logic        coef_we_s    [2];
    logic [1:0]  coef_addr_s  [2];
    logic [15:0] coef_wdata_s [2];
    logic        in_valid_s   [2];
    logic [31:0] in_data_s    [2];

    logic               ov_a;
    logic signed [31:0] od_a;
    logic               os_a;
    logic               ov_b;
    logic signed [15:0] od_b;
    logic               os_b;

    fir_feedforward_param #(.DATA_W(32), .COEF_W(16), .TAPS(3), .OUT_SHIFT(0)) u_dut_a (
        .clk(clk_s), .rst_n(rst_n_s), .flush(flush_s[0]), .coef_we(coef_we_s[0]),
        .coef_addr(coef_addr_s[0]), .coef_wdata(coef_wdata_s[0]), .in_valid(in_valid_s[0]),
        .in_data(in_data_s[0]), .out_valid(ov_a), .out_data(od_a), .out_sat(os_a));

    fir_feedforward_param #(.DATA_W(16), .COEF_W(16), .TAPS(3), .OUT_SHIFT(2)) u_dut_b (
        .clk(clk_s), .rst_n(rst_n_s), .flush(flush_s[1]), .coef_we(coef_we_s[1]),
        .coef_addr(coef_addr_s[1]), .coef_wdata(coef_wdata_s[1]), .in_valid(in_valid_s[1]),
        .in_data(in_data_s[1][15:0]), .out_valid(ov_b), .out_data(od_b), .out_sat(os_b));

    typedef struct {
        int     dut;
        int     due;
        longint data;
        bit     sat;
    } exp_t;

    exp_t   expq [$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;
    longint h_m    [2][3];
    longint hist_m [2][3];
    longint last_d [2];
    bit     last_s [2];

    function automatic void chk(input string tag, input longint obs, input longint exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) begin
                h_m[d][k]    = 0;
                hist_m[d][k] = 0;
            end
            last_d[d] = 0;
            last_s[d] = 1'b0;
        end
        expq.delete();
    endtask

    // y = sum h[k]*x[n-k], then round-half-up shift and clamp, due four edges from now.
    task automatic model_edge(input int d);
        longint acc, r, lim;
        bit     s;
        int     sh, dw;
        sh = (d == 0) ? 0 : 2;
        dw = (d == 0) ? 32 : 16;
        if (coef_we_s[d] && coef_addr_s[d] < 2'd3)
            h_m[d][coef_addr_s[d]] = longint'($signed(coef_wdata_s[d]));
        if (flush_s[d]) begin
            for (int k = 0; k < 3; k++) hist_m[d][k] = 0;
            for (int i = expq.size() - 1; i >= 0; i--)
                if (expq[i].dut == d) expq.delete(i);
        end else if (in_valid_s[d]) begin
            for (int k = 2; k > 0; k--) hist_m[d][k] = hist_m[d][k-1];
            if (d == 0) hist_m[d][0] = longint'($signed(in_data_s[d]));
            else        hist_m[d][0] = longint'($signed(in_data_s[d][15:0]));
            acc = 0;
            for (int k = 0; k < 3; k++) acc += h_m[d][k] * hist_m[d][k];
            if (sh > 0) r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
            else        r = acc;
            lim = longint'(1) <<< (dw - 1);
            s   = 1'b0;
            if (r > lim - 1)   begin r = lim - 1; s = 1'b1; end
            else if (r < -lim) begin r = -lim;    s = 1'b1; end
            expq.push_back('{dut: d, due: cyc + 4, data: r, sat: s});
        end
    endtask

    task automatic check_out(input int d);
        bit     v, s, ev;
        longint od;
        int     idx;
        idx = -1;
        if (d == 0) begin v = ov_a; od = longint'(od_a); s = os_a; end
        else        begin v = ov_b; od = longint'(od_b); s = os_b; end
        for (int i = 0; i < expq.size(); i++)
            if (expq[i].dut == d) begin idx = i; break; end
        ev = (idx >= 0) && (expq[idx].due == cyc);
        chk($sformatf("valid_d%0d_c%0d", d, cyc), longint'(v), longint'(ev));
        if (ev) begin
            chk($sformatf("data_d%0d_c%0d", d, cyc), od, expq[idx].data);
            chk($sformatf("sat_d%0d_c%0d", d, cyc), longint'(s), longint'(expq[idx].sat));
            last_d[d] = expq[idx].data;
            last_s[d] = expq[idx].sat;
            expq.delete(idx);
        end else if (!v) begin
            chk($sformatf("hold_data_d%0d_c%0d", d, cyc), od, last_d[d]);
            chk($sformatf("hold_sat_d%0d_c%0d", d, cyc), longint'(s), longint'(last_s[d]));
        end else begin
            last_d[d] = od;
            last_s[d] = s;
        end
        for (int i = expq.size() - 1; i >= 0; i--)
            if (expq[i].dut == d && expq[i].due <= cyc) expq.delete(i);
    endtask

    task automatic step();
        for (int d = 0; d < 2; d++) model_edge(d);
        @(posedge clk_s);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) check_out(d);
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            flush_s[d]      = 1'b0;
            coef_we_s[d]    = 1'b0;
            coef_addr_s[d]  = 2'd0;
            coef_wdata_s[d] = 16'd0;
            in_valid_s[d]   = 1'b0;
            in_data_s[d]    = 32'd0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int d, input longint v);
        in_valid_s[d] = 1'b1;
        in_data_s[d]  = 32'(v);
        step();
        in_valid_s[d] = 1'b0;
    endtask

    task automatic wcoef(input int d, input int a, input longint v);
        coef_we_s[d]    = 1'b1;
        coef_addr_s[d]  = 2'(a);
        coef_wdata_s[d] = 16'(v);
        step();
        coef_we_s[d] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ov_a"}, longint'(ov_a), 0);
        chk({tag, "_od_a"}, longint'(od_a), 0);
        chk({tag, "_os_a"}, longint'(os_a), 0);
        chk({tag, "_ov_b"}, longint'(ov_b), 0);
        chk({tag, "_od_b"}, longint'(od_b), 0);
        chk({tag, "_os_b"}, longint'(os_b), 0);
    endtask

    initial begin
        logic [31:0] r_v;
        idle_all();
        reset_model();
        #1 rst_n_s = 1'b0;
        #6 check_reset_outputs("reset");
        #5 rst_n_s = 1'b1;

        // Impulse response through h = {3,-2,5}.
        wcoef(0, 0, 3);
        wcoef(0, 1, -2);
        wcoef(0, 2, 5);
        send(0, 1); send(0, 0); send(0, 0); send(0, 0);
        idle(4);

        // Gapped samples: 10, two idle cycles, 20.
        send(0, 10);
        idle(2);
        send(0, 20);
        idle(4);

        // Rounding and saturation on the 16-bit, shift-2 instance.
        wcoef(1, 0, 1);
        send(1, 7);
        idle(4);
        wcoef(1, 0, 32767);
        send(1, 32767);
        idle(4);
        send(1, -32768);
        idle(4);

        // Coefficient change while streaming constant 1s, then an out-of-range write.
        wcoef(0, 0, 1); wcoef(0, 1, 1); wcoef(0, 2, 1);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 32'd1;
        idle(4);
        coef_we_s[0] = 1'b1; coef_addr_s[0] = 2'd0; coef_wdata_s[0] = 16'd4;
        step();
        coef_we_s[0] = 1'b0;
        idle(2);
        coef_we_s[0] = 1'b1; coef_addr_s[0] = 2'd3; coef_wdata_s[0] = 16'd100;
        step();
        coef_we_s[0] = 1'b0;
        idle(3);
        in_valid_s[0] = 1'b0;
        idle(4);

        // Flush with a coincident sample drops it and zeroes the line.
        wcoef(0, 0, 1);
        idle(3);
        send(0, 5);
        send(0, 5);
        flush_s[0] = 1'b1; in_valid_s[0] = 1'b1; in_data_s[0] = 32'd9;
        step();
        flush_s[0] = 1'b0; in_valid_s[0] = 1'b0;
        idle(3);
        send(0, 1);
        idle(4);

        // Randomised traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            for (int d = 0; d < 2; d++) begin
                r_v = $urandom();
                in_valid_s[d]   = ($urandom_range(9, 0) < 7);
                in_data_s[d]    = ($urandom_range(1, 0) == 1) ? $urandom() : {{20{r_v[11]}}, r_v[11:0]};
                coef_we_s[d]    = ($urandom_range(9, 0) == 0);
                coef_addr_s[d]  = 2'($urandom_range(3, 0));
                coef_wdata_s[d] = 16'($urandom());
                flush_s[d]      = ($urandom_range(39, 0) == 0);
            end
            step();
        end
        idle_all();
        idle(5);

        // Asynchronous reset in the middle of a burst.
        wcoef(0, 0, 1); wcoef(0, 1, 1); wcoef(0, 2, 1);
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 32'd7;
        idle(4);
        rst_n_s = 1'b0;
        #2 check_reset_outputs("midreset");
        reset_model();
        #2 rst_n_s = 1'b1;
        in_valid_s[0] = 1'b0;
        send(0, 1);
        idle(6);

        chk("leftover_expected", longint'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fir_feedforward_param.md
Name: fir_feedforward_param

Overview:
- Parametrised, pipelined feed-forward (FIR) section for the IIR filter datapath.
- Computes y[n] = sum over k = 0..TAPS-1 of h[k]*x[n-k] on a valid-qualified sample stream.
- Signed arithmetic, run-time programmable coefficients, rounding and output saturation.
- Sits ahead of the feedback section; its out_data drives the feedback adder.

Parameters:
- DATA_W, 32: signed input/output sample width.
- COEF_W, 16: signed coefficient width.
- TAPS, 3: number of taps, TAPS >= 1; h[0] applies to the current sample.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- ACC_W, DATA_W+COEF_W+$clog2(TAPS)+1: internal accumulator width (derived; must not be overridden smaller).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous clear of the delay line and pipeline valids; coefficients are kept.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS) (min 1)  tap index to write.
- coef_wdata  in  COEF_W  signed coefficient value.
- in_valid  in  1  input sample qualifier.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output sample qualifier.
- out_data  out  DATA_W  signed filtered sample.
- out_sat  out  1  the current out_data was saturated; meaningful only when out_valid=1.

Behaviour:
- Reset: all h[k]=0, delay line x[0..TAPS-1]=0, pipeline valids=0, out_valid=0, out_data=0, out_sat=0.
- Pipeline stages; the block is always ready and applies no back-pressure.
  - S0, accept: on in_valid, shift x[k] <= x[k-1] and load x[0] <= in_data. The line shifts only on accepted samples; idle cycles do not advance it.
  - S1, multiply: register p[k] = x[k]*h[k], full signed width DATA_W+COEF_W.
  - S2, sum: register acc = sum of p[k], sign-extended to ACC_W.
  - S3, output: register the scaled result as out_data; assert out_valid for exactly one cycle.
- Latency: out_valid rises 3 cycles after the in_valid edge. Back-to-back samples give one output per cycle.
- Scaling: if OUT_SHIFT > 0, r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up); if OUT_SHIFT = 0, r = acc.
- Saturation: if r > 2^(DATA_W-1)-1, output the max value with out_sat=1; if r < -2^(DATA_W-1), output the min value with out_sat=1; otherwise output r with out_sat=0.
- Coefficient write:
  - h[coef_addr] <= coef_wdata at the clock edge.
  - A sample in S1 on the same edge uses the old value; samples reaching S1 afterwards use the new value.
  - coef_addr >= TAPS: the write is ignored.
- Simultaneous events:
  - flush with in_valid: flush wins; the delay line is zeroed and the sample is dropped.
  - flush: in-flight S1..S3 valids are cleared; out_valid=0 on the next cycle; out_data holds its last value.
  - coef_we with in_valid: both take effect, each independently.
- Reset mid-stream: asynchronous clear of all state, including coefficients; in-flight samples are lost.
- Between outputs, out_data and out_sat hold their last values.

Decomposition:
- Shared package fir_pkg holds:
  - the function clog2_min1;
  - the saturation function sat_round(acc, shift, width);
  - the default widths.
- Natural sub-module: fir_tap_mult, one registered signed multiply per tap, generated TAPS times.
- The S0 delay line, adder tree and output stage stay in the top module.

Test Plan:
- Impulse: TAPS=3, OUT_SHIFT=0, h={3,-2,5}. Drive the 4-sample burst 1,0,0,0 -> out_data 3,-2,5,0, each with out_valid 3 cycles after its input, out_sat=0.
- Gapped input: same coefficients, samples 10 and 20 with 2 idle cycles between them -> outputs 30 then 40; exactly two out_valid pulses, no output on idle cycles.
- Rounding/saturation with DATA_W=16, OUT_SHIFT=2:
  - h={1,0,0}, input 7 -> out 2.
  - h={32767,0,0}, input 32767 -> out 32767, out_sat=1.
  - input -32768 -> out -32768, out_sat=1.
- Coefficient change mid-stream: constant input 1, h={1,1,1} giving steady output 3. Write h[0]=4 on the cycle a sample sits in S1 -> that sample outputs 3, the next outputs 6. Write to coef_addr=3 -> no change.
- Flush: stream 5,5 then flush with in_valid=1 and data 9 -> no outputs after the flush. The next input 1 with h={1,1,1} -> out 1 (delay line was zeroed).
- Reset: assert rst_n=0 mid-burst -> out_valid=0, out_data=0 immediately (asynchronous). After release, input 1 -> out 0 (coefficients cleared).
